// File: rtl/fetch_multi_if.sv
// Fetch-unit signal bundle: exception/restart control, memory-side request and
// response, and the decode-side group output. master = fetch unit, slave = its environment.
interface fetch_multi_if #(
  parameter int P_WIDTH = 2
);
  logic                   iEXCEPTION_EVENT;
  logic                   iEXCEPTION_ADDR_SET;
  logic [31:0]            iEXCEPTION_ADDR;
  logic                   iEXCEPTION_RESTART;
  logic                   iEXCEPTION_INST_DISCARD;
  logic                   iFETCH_STOP;
  logic [P_WIDTH-1:0]     iPREVIOUS_INST_VALID;
  logic [6*P_WIDTH-1:0]   iPREVIOUS_MMU_FLAGS;
  logic [32*P_WIDTH-1:0]  iPREVIOUS_INST;
  logic                   oPREVIOUS_LOCK;
  logic                   oPREVIOUS_FETCH_REQ;
  logic [31:0]            oPREVIOUS_FETCH_ADDR;
  logic                   iPREVIOUS_FETCH_LOCK;
  logic [P_WIDTH-1:0]     oNEXT_INST_VALID;
  logic [6*P_WIDTH-1:0]   oNEXT_MMU_FLAGS;
  logic [32*P_WIDTH-1:0]  oNEXT_INST;
  logic [31:0]            oNEXT_PC;
  logic                   iNEXT_LOCK;

  modport master (
    input  iEXCEPTION_EVENT, iEXCEPTION_ADDR_SET, iEXCEPTION_ADDR, iEXCEPTION_RESTART,
           iEXCEPTION_INST_DISCARD, iFETCH_STOP, iPREVIOUS_INST_VALID, iPREVIOUS_MMU_FLAGS,
           iPREVIOUS_INST, iPREVIOUS_FETCH_LOCK, iNEXT_LOCK,
    output oPREVIOUS_LOCK, oPREVIOUS_FETCH_REQ, oPREVIOUS_FETCH_ADDR,
           oNEXT_INST_VALID, oNEXT_MMU_FLAGS, oNEXT_INST, oNEXT_PC
  );

  modport slave (
    output iEXCEPTION_EVENT, iEXCEPTION_ADDR_SET, iEXCEPTION_ADDR, iEXCEPTION_RESTART,
           iEXCEPTION_INST_DISCARD, iFETCH_STOP, iPREVIOUS_INST_VALID, iPREVIOUS_MMU_FLAGS,
           iPREVIOUS_INST, iPREVIOUS_FETCH_LOCK, iNEXT_LOCK,
    input  oPREVIOUS_LOCK, oPREVIOUS_FETCH_REQ, oPREVIOUS_FETCH_ADDR,
           oNEXT_INST_VALID, oNEXT_MMU_FLAGS, oNEXT_INST, oNEXT_PC
  );
endinterface

// File: rtl/fetch_multi.sv
// Multi-issue fetch unit: issues aligned group requests, tracks them in an
// address queue, and realigns returned groups toward decode after a misaligned restart.
module fetch_multi #(
  parameter int P_WIDTH         = 2,
  parameter int P_QUEUE_DEPTH   = 8,
  parameter int P_QUEUE_DEPTH_N = 3
) (
  input  logic          iCLOCK,
  input  logic          iRESET_SYNC,
  fetch_multi_if.master bus
);
  localparam int W  = P_WIDTH;
  localparam int G  = 4 * W;
  localparam int S  = (W > 1) ? $clog2(W) : 1;
  localparam int QN = P_QUEUE_DEPTH_N;

  typedef enum logic [1:0] {RESET_START, FETCH, WAIT_RESTART} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [S-1:0]  pend_reg, pend_next;
  logic          issue;
  logic [31:0]   restart_pc;
  logic [S-1:0]  restart_off;

  logic [31:0]   q_addr_mem [P_QUEUE_DEPTH];
  logic [S-1:0]  q_off_mem  [P_QUEUE_DEPTH];
  logic [QN-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [QN:0]   count_reg;
  logic          q_full, q_empty, do_pop;
  logic [31:0]   head_addr;
  logic [S-1:0]  head_off;

  logic [W-1:0]    valid_next, valid_reg;
  logic [6*W-1:0]  flags_next, flags_reg;
  logic [32*W-1:0] inst_next, inst_reg;
  logic [31:0]     npc_reg;

  assign restart_pc  = bus.iEXCEPTION_ADDR & ~32'(G - 1);
  assign restart_off = S'((bus.iEXCEPTION_ADDR >> 2) & 32'(W - 1));

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_reg <= RESET_START;
      pc_reg    <= '0;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pend_next  = pend_reg;
    issue      = 1'b0;
    case (state_reg)
      RESET_START: begin
        state_next = FETCH;
        pc_next    = '0;
        pend_next  = '0;
      end
      FETCH: begin
        issue = !bus.iEXCEPTION_EVENT && !q_full && !bus.iPREVIOUS_FETCH_LOCK &&
                !bus.iFETCH_STOP && !iRESET_SYNC;
        if (issue) begin
          pc_next   = pc_reg + 32'(G);
          pend_next = '0;
        end
      end
      WAIT_RESTART: begin
        if (bus.iEXCEPTION_ADDR_SET && bus.iEXCEPTION_RESTART && !bus.iEXCEPTION_EVENT) begin
          pc_next    = restart_pc;
          pend_next  = restart_off;
          state_next = FETCH;
        end
      end
      default: state_next = RESET_START;
    endcase
    if (bus.iEXCEPTION_EVENT) state_next = WAIT_RESTART;
  end

  // Address queue: small register array so the head entry is readable in the same cycle as its response.
  assign q_full  = (count_reg == (QN+1)'(P_QUEUE_DEPTH));
  assign q_empty = (count_reg == '0);
  assign do_pop  = (|bus.iPREVIOUS_INST_VALID) && !q_empty;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || bus.iEXCEPTION_RESTART) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (issue)  wr_ptr_reg <= wr_ptr_reg + QN'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + QN'(1);
      case ({issue, do_pop})
        2'b10:   count_reg <= count_reg + (QN+1)'(1);
        2'b01:   count_reg <= count_reg - (QN+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (issue) begin
      q_addr_mem[wr_ptr_reg] <= pc_reg;
      q_off_mem[wr_ptr_reg]  <= pend_reg;
    end
  end

  // An empty queue reads as offset 0 / address 0 so the output path stays deterministic.
  assign head_addr = q_empty ? '0 : q_addr_mem[rd_ptr_reg];
  assign head_off  = q_empty ? '0 : q_off_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_slot
      logic [31:0] slot_inst;
      logic [5:0]  slot_flags;
      logic        slot_valid;
      int          src;
      always_comb begin
        src        = gi + int'(head_off);
        slot_inst  = '0;
        slot_flags = '0;
        slot_valid = 1'b0;
        if (src < W) begin
          slot_inst  = bus.iPREVIOUS_INST[src*32 +: 32];
          slot_flags = bus.iPREVIOUS_MMU_FLAGS[src*6 +: 6];
          slot_valid = bus.iPREVIOUS_INST_VALID[src] && !bus.iEXCEPTION_INST_DISCARD;
        end
      end
      assign inst_next[gi*32 +: 32] = slot_inst;
      assign flags_next[gi*6 +: 6]  = slot_flags;
      assign valid_next[gi]         = slot_valid;
    end
  endgenerate

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || bus.iEXCEPTION_EVENT) begin
      valid_reg <= '0;
      flags_reg <= '0;
      inst_reg  <= '0;
      npc_reg   <= '0;
    end else if (!bus.iNEXT_LOCK) begin
      valid_reg <= valid_next;
      flags_reg <= flags_next;
      inst_reg  <= inst_next;
      npc_reg   <= head_addr + (32'(head_off) << 2);
    end
  end

  assign bus.oPREVIOUS_FETCH_REQ  = issue;
  assign bus.oPREVIOUS_FETCH_ADDR = pc_reg;
  assign bus.oPREVIOUS_LOCK       = bus.iEXCEPTION_INST_DISCARD ? 1'b0 : bus.iNEXT_LOCK;
  assign bus.oNEXT_INST_VALID     = valid_reg & {W{~bus.iNEXT_LOCK}};
  assign bus.oNEXT_MMU_FLAGS      = flags_reg;
  assign bus.oNEXT_INST           = inst_reg;
  assign bus.oNEXT_PC             = npc_reg;
endmodule
